// File: rtl/avalon_mm_clock_crossing_bridge_if.sv
// Avalon-MM signal bundle for the clock-crossing bridge. The slave modport is the
// CPU-facing side of the bridge, the master modport is the peripheral-facing side.
interface avalon_mm_clock_crossing_bridge_if #(
   parameter int DATA_W            = 32,
   parameter int ADDR_W            = 20,
   parameter int MAX_PENDING_READS = 32
);
   localparam int BE_W    = DATA_W / 8;
   localparam int PEND_W  = $clog2(MAX_PENDING_READS + 1);
   localparam int MADDR_W = ADDR_W + $clog2(BE_W);

   logic [ADDR_W-1:0]  slave_address;
   logic [BE_W-1:0]    slave_byteenable;
   logic               slave_read;
   logic               slave_write;
   logic [DATA_W-1:0]  slave_writedata;
   logic               slave_waitrequest;
   logic [DATA_W-1:0]  slave_readdata;
   logic               slave_readdatavalid;
   logic [PEND_W-1:0]  slave_pending_reads;

   logic [MADDR_W-1:0] master_address;
   logic [BE_W-1:0]    master_byteenable;
   logic               master_read;
   logic               master_write;
   logic [DATA_W-1:0]  master_writedata;
   logic               master_waitrequest;
   logic [DATA_W-1:0]  master_readdata;
   logic               master_readdatavalid;

   modport slave (
      input  slave_address, slave_byteenable, slave_read, slave_write, slave_writedata,
      output slave_waitrequest, slave_readdata, slave_readdatavalid, slave_pending_reads
   );

   modport master (
      output master_address, master_byteenable, master_read, master_write, master_writedata,
      input  master_waitrequest, master_readdata, master_readdatavalid
   );
endinterface

// File: rtl/avalon_mm_clock_crossing_bridge.sv
// Avalon-MM clock-crossing bridge: gray-pointer command FIFO toward master_clk, response
// FIFO back toward slave_clk, with a read-credit counter that keeps the response FIFO safe.
module avalon_mm_clock_crossing_bridge #(
   parameter int DATA_W            = 32,
   parameter int ADDR_W            = 20,
   parameter int CMD_DEPTH         = 16,
   parameter int RSP_DEPTH         = 32,
   parameter int MAX_PENDING_READS = 32,
   parameter int SYNC_STAGES       = 2
) (
   input logic slave_clk,
   input logic slave_reset_n,
   input logic master_clk,
   input logic master_reset_n,
   avalon_mm_clock_crossing_bridge_if.slave  slave_bus,
   avalon_mm_clock_crossing_bridge_if.master master_bus
);
   localparam int BE_W    = DATA_W / 8;
   localparam int LSB_W   = $clog2(BE_W);
   localparam int MADDR_W = ADDR_W + LSB_W;
   localparam int PEND_W  = $clog2(MAX_PENDING_READS + 1);
   localparam int CMD_W   = 1 + ADDR_W + BE_W + DATA_W;
   localparam int CAW     = $clog2(CMD_DEPTH);
   localparam int RAW     = $clog2(RSP_DEPTH);

   logic [SYNC_STAGES-1:0] m_rst_in_s, s_rst_in_m;
   logic s_rst, m_rst;

   // Each reset reaches the other domain asserted immediately and released synchronously.
   always_ff @(posedge slave_clk or negedge master_reset_n)
      if (!master_reset_n) m_rst_in_s <= '0;
      else                 m_rst_in_s <= {m_rst_in_s[SYNC_STAGES-2:0], 1'b1};

   always_ff @(posedge master_clk or negedge slave_reset_n)
      if (!slave_reset_n) s_rst_in_m <= '0;
      else                s_rst_in_m <= {s_rst_in_m[SYNC_STAGES-2:0], 1'b1};

   assign s_rst = !slave_reset_n  | !m_rst_in_s[SYNC_STAGES-1];
   assign m_rst = !master_reset_n | !s_rst_in_m[SYNC_STAGES-1];

   logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
   logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];

   logic [CAW:0] cmd_wr_bin, cmd_wr_gray, cmd_wr_next, cmd_rd_bin, cmd_rd_gray, cmd_rd_next;
   logic [CAW:0] cmd_rd_sync [SYNC_STAGES];
   logic [CAW:0] cmd_wr_sync [SYNC_STAGES];
   logic [RAW:0] rsp_wr_bin, rsp_wr_gray, rsp_wr_next, rsp_rd_bin, rsp_rd_gray, rsp_rd_next;
   logic [RAW:0] rsp_rd_sync [SYNC_STAGES];
   logic [RAW:0] rsp_wr_sync [SYNC_STAGES];

   logic              cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic              rd_only, waitrequest, accept, read_accept, cmd_pop, rsp_push, rsp_pop;
   logic [PEND_W-1:0] pending;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [CMD_W-1:0]  head;

   assign cmd_wr_next = cmd_wr_bin + 1'b1;
   assign cmd_rd_next = cmd_rd_bin + 1'b1;
   assign rsp_wr_next = rsp_wr_bin + 1'b1;
   assign rsp_rd_next = rsp_rd_bin + 1'b1;

   // Full means the write pointer has lapped the read pointer: top two gray bits inverted.
   assign cmd_full  = cmd_wr_gray == {~cmd_rd_sync[SYNC_STAGES-1][CAW -: 2], cmd_rd_sync[SYNC_STAGES-1][CAW-2:0]};
   assign cmd_empty = cmd_rd_gray == cmd_wr_sync[SYNC_STAGES-1];
   assign rsp_full  = rsp_wr_gray == {~rsp_rd_sync[SYNC_STAGES-1][RAW -: 2], rsp_rd_sync[SYNC_STAGES-1][RAW-2:0]};
   assign rsp_empty = rsp_rd_gray == rsp_wr_sync[SYNC_STAGES-1];

   assign rd_only     = slave_bus.slave_read & !slave_bus.slave_write;
   assign waitrequest = s_rst | cmd_full | (rd_only & (pending == PEND_W'(MAX_PENDING_READS)));
   assign accept      = (slave_bus.slave_read | slave_bus.slave_write) & !waitrequest;
   assign read_accept = accept & rd_only;
   assign rsp_pop     = !rsp_empty;

   always_ff @(posedge slave_clk)
      if (accept)
         cmd_mem[cmd_wr_bin[CAW-1:0]] <= {rd_only, slave_bus.slave_address,
                                          slave_bus.slave_byteenable, slave_bus.slave_writedata};

   // Slave domain: command write pointer, pointer synchronisers, credits and response drain.
   always_ff @(posedge slave_clk or posedge s_rst)
      if (s_rst) begin
         cmd_wr_bin  <= '0;
         cmd_wr_gray <= '0;
         rsp_rd_bin  <= '0;
         rsp_rd_gray <= '0;
         pending     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            cmd_rd_sync[i] <= '0;
            rsp_wr_sync[i] <= '0;
         end
      end else begin
         cmd_rd_sync[0] <= cmd_rd_gray;
         rsp_wr_sync[0] <= rsp_wr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            cmd_rd_sync[i] <= cmd_rd_sync[i-1];
            rsp_wr_sync[i] <= rsp_wr_sync[i-1];
         end
         if (accept) begin
            cmd_wr_bin  <= cmd_wr_next;
            cmd_wr_gray <= cmd_wr_next ^ (cmd_wr_next >> 1);
         end
         if (read_accept && !rsp_valid)
            pending <= pending + 1'b1;
         else if (!read_accept && rsp_valid && pending != '0)
            pending <= pending - 1'b1;
         rsp_valid <= rsp_pop;
         if (rsp_pop) begin
            rsp_data    <= rsp_mem[rsp_rd_bin[RAW-1:0]];
            rsp_rd_bin  <= rsp_rd_next;
            rsp_rd_gray <= rsp_rd_next ^ (rsp_rd_next >> 1);
         end
      end

   assign head     = cmd_mem[cmd_rd_bin[CAW-1:0]];
   assign cmd_pop  = !cmd_empty & !master_bus.master_waitrequest;
   assign rsp_push = master_bus.master_readdatavalid & !m_rst;

   always_ff @(posedge master_clk)
      if (rsp_push)
         rsp_mem[rsp_wr_bin[RAW-1:0]] <= master_bus.master_readdata;

   // Master domain: command read pointer, response write pointer and their synchronisers.
   always_ff @(posedge master_clk or posedge m_rst)
      if (m_rst) begin
         cmd_rd_bin  <= '0;
         cmd_rd_gray <= '0;
         rsp_wr_bin  <= '0;
         rsp_wr_gray <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            cmd_wr_sync[i] <= '0;
            rsp_rd_sync[i] <= '0;
         end
      end else begin
         cmd_wr_sync[0] <= cmd_wr_gray;
         rsp_rd_sync[0] <= rsp_rd_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            cmd_wr_sync[i] <= cmd_wr_sync[i-1];
            rsp_rd_sync[i] <= rsp_rd_sync[i-1];
         end
         if (cmd_pop) begin
            cmd_rd_bin  <= cmd_rd_next;
            cmd_rd_gray <= cmd_rd_next ^ (cmd_rd_next >> 1);
         end
         if (rsp_push) begin
            assert (!rsp_full);
            rsp_wr_bin  <= rsp_wr_next;
            rsp_wr_gray <= rsp_wr_next ^ (rsp_wr_next >> 1);
         end
      end

   assign slave_bus.slave_waitrequest   = waitrequest;
   assign slave_bus.slave_readdata      = rsp_data;
   assign slave_bus.slave_readdatavalid = rsp_valid;
   assign slave_bus.slave_pending_reads = pending;

   // The idle bus (which includes reset, since the pointers clear) drives all zeros.
   assign master_bus.master_read       = !cmd_empty &  head[CMD_W-1];
   assign master_bus.master_write      = !cmd_empty & !head[CMD_W-1];
   assign master_bus.master_address    = cmd_empty ? '0 : MADDR_W'(head[CMD_W-2 -: ADDR_W]) << LSB_W;
   assign master_bus.master_byteenable = cmd_empty ? '0 : head[DATA_W+BE_W-1 -: BE_W];
   assign master_bus.master_writedata  = cmd_empty ? '0 : head[DATA_W-1:0];
endmodule

// File: tb/tb_avalon_mm_clock_crossing_bridge.sv
// Directed-plus-random bench for the clock-crossing bridge: a command/read-data scoreboard
// plus a latency-10 downstream model check ordering, stalls, credits and reset flushing.
module tb_avalon_mm_clock_crossing_bridge;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 20;
   localparam int MAXP   = 32;
   localparam int SYNC   = 2;
   localparam int BE_W   = DATA_W / 8;

   typedef struct packed {
      logic              is_read;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] data;
   } cmd_t;

   logic slave_clk = 1'b0;
   logic master_clk = 1'b0;
   logic slave_reset_n = 1'b0;
   logic master_reset_n = 1'b0;

   always #100 slave_clk = ~slave_clk;
   always #185 master_clk = ~master_clk;

   avalon_mm_clock_crossing_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PENDING_READS(MAXP)) bus ();

   avalon_mm_clock_crossing_bridge #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_DEPTH(16), .RSP_DEPTH(32),
      .MAX_PENDING_READS(MAXP), .SYNC_STAGES(SYNC)
   ) dut (
      .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
      .master_clk(master_clk), .master_reset_n(master_reset_n),
      .slave_bus(bus), .master_bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   cmd_t              exp_cmd[$];
   logic [DATA_W-1:0] exp_rd[$];
   int                rsp_due[$];
   logic [DATA_W-1:0] rsp_data[$];

   int   mcycle = 0;
   int   stall_mode = 0;
   bit   hold_rsp = 1'b0;
   bit   mon_enable = 1'b0;
   int   master_issued = 0;
   int   rd_returned = 0;
   logic [ADDR_W+1:0] last_addr = '0;
   logic        prev_stalled = 1'b0;
   logic [63:0] prev_bus = '0;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Downstream peripheral: random or fixed stall, in-order read data equal to the byte address.
   always @(negedge master_clk) begin
      logic [63:0] cur;
      logic        req;
      cmd_t        e;
      mcycle++;
      if (!hold_rsp && rsp_due.size() > 0 && rsp_due[0] <= mcycle) begin
         bus.master_readdatavalid = 1'b1;
         bus.master_readdata      = rsp_data.pop_front();
         void'(rsp_due.pop_front());
      end else begin
         bus.master_readdatavalid = 1'b0;
      end
      case (stall_mode)
         0:       bus.master_waitrequest = 1'b0;
         1:       bus.master_waitrequest = 1'b1;
         default: bus.master_waitrequest = 1'($urandom_range(0, 1));
      endcase
      cur = {4'h0, bus.master_read, bus.master_write, bus.master_address,
             bus.master_byteenable, bus.master_writedata};
      if (prev_stalled && mon_enable)
         check_output("stall_hold", cur, prev_bus);
      req          = bus.master_read | bus.master_write;
      prev_stalled = req & bus.master_waitrequest & mon_enable;
      prev_bus     = cur;
      if (req && !bus.master_waitrequest) begin
         master_issued++;
         last_addr = bus.master_address;
         check_output("cmd_expected", 64'(exp_cmd.size() > 0), 64'd1);
         if (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            check_output("cmd_kind", {bus.master_read, bus.master_write}, {e.is_read, !e.is_read});
            check_output("cmd_addr", bus.master_address, {e.addr, 2'b00});
            check_output("cmd_be", bus.master_byteenable, e.be);
            check_output("cmd_data", bus.master_writedata, e.data);
         end
         if (bus.master_read) begin
            rsp_due.push_back(mcycle + 10);
            rsp_data.push_back(DATA_W'(bus.master_address));
         end
      end
   end

   // Read data returning on the slave port is compared in read order.
   always @(negedge slave_clk) begin
      if (slave_reset_n && bus.slave_readdatavalid) begin
         rd_returned++;
         check_output("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
         if (exp_rd.size() > 0)
            check_output("rd_data", bus.slave_readdata, exp_rd.pop_front());
      end
   end

   // Present one command from a slave negedge; it is accepted at the next posedge without waitrequest.
   task automatic apply_stimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data,
                                 input int budget, output bit ok);
      cmd_t c;
      ok = 1'b0;
      bus.slave_read       = rd;
      bus.slave_write      = wr;
      bus.slave_address    = addr;
      bus.slave_byteenable = be;
      bus.slave_writedata  = data;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (!bus.slave_waitrequest) begin
            ok        = 1'b1;
            c.is_read = rd & !wr;
            c.addr    = addr;
            c.be      = be;
            c.data    = data;
            exp_cmd.push_back(c);
            if (rd && !wr) exp_rd.push_back(DATA_W'({addr, 2'b00}));
            @(negedge slave_clk);
            break;
         end
         @(negedge slave_clk);
      end
      bus.slave_read  = 1'b0;
      bus.slave_write = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_cmd.size() > 0 || exp_rd.size() > 0 || rsp_due.size() > 0) && n < 4000) begin
         @(negedge slave_clk);
         n++;
      end
      check_output(tag, 64'(n < 4000), 64'd1);
      repeat (10) @(negedge slave_clk);
   endtask

   initial begin
      #20_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      int base_issued, base_rd, accepted;
      logic [ADDR_W-1:0] full_addr[20];
      logic [DATA_W-1:0] full_data[20];
      logic rd;

      bus.slave_read = 1'b0;  bus.slave_write = 1'b0;
      bus.slave_address = '0; bus.slave_byteenable = '0; bus.slave_writedata = '0;
      bus.master_waitrequest = 1'b0; bus.master_readdata = '0; bus.master_readdatavalid = 1'b0;

      repeat (4) @(negedge slave_clk);
      #1;
      check_output("rst_waitrequest", bus.slave_waitrequest, 1);
      check_output("rst_rdvalid", bus.slave_readdatavalid, 0);
      check_output("rst_rddata", bus.slave_readdata, 0);
      check_output("rst_pending", bus.slave_pending_reads, 0);
      check_output("rst_master_rw", {bus.master_read, bus.master_write}, 0);
      check_output("rst_master_bus", {bus.master_address, bus.master_byteenable, bus.master_writedata}, 0);

      @(negedge slave_clk);
      master_reset_n = 1'b1;
      slave_reset_n  = 1'b1;
      mon_enable     = 1'b1;
      repeat (8) @(negedge slave_clk);
      #1 check_output("idle_waitrequest", bus.slave_waitrequest, 0);
      @(negedge slave_clk);

      $display("[TB] single write");
      base_issued = master_issued;
      apply_stimulus(1'b0, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 1, ok);
      check_output("single_wr_accept", ok, 1);
      wait_drain("single_wr_drain");
      check_output("single_wr_count", master_issued - base_issued, 1);
      check_output("single_wr_addr", last_addr, 22'h00040);

      $display("[TB] read burst beyond credit");
      base_rd  = rd_returned;
      hold_rsp = 1'b1;
      for (int i = 0; i < 32; i++) begin
         apply_stimulus(1'b1, 1'b0, ADDR_W'($urandom), 4'hF, $urandom, 50, ok);
         check_output("burst_rd_accept", ok, 1);
      end
      check_output("burst_pending_max", bus.slave_pending_reads, 32);
      apply_stimulus(1'b1, 1'b0, ADDR_W'($urandom), 4'hF, $urandom, 20, ok);
      check_output("credit_block", ok, 0);
      apply_stimulus(1'b0, 1'b1, ADDR_W'($urandom), 4'h3, $urandom, 50, ok);
      check_output("write_at_max_credit", ok, 1);
      hold_rsp = 1'b0;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b0, ADDR_W'($urandom), 4'hF, $urandom, 400, ok);
         check_output("burst_rd_tail_accept", ok, 1);
      end
      wait_drain("burst_drain");
      check_output("burst_rd_count", rd_returned - base_rd, 40);
      check_output("burst_pending_zero", bus.slave_pending_reads, 0);

      $display("[TB] command FIFO full");
      stall_mode = 1;
      repeat (3) @(negedge slave_clk);
      base_issued = master_issued;
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         full_addr[i] = ADDR_W'($urandom);
         full_data[i] = $urandom;
         apply_stimulus(1'b0, 1'b1, full_addr[i], 4'hF, full_data[i], 3, ok);
         if (ok) accepted++;
      end
      check_output("full_accept_count", accepted, 16);
      bus.slave_write = 1'b1;
      #1 check_output("full_waitrequest", bus.slave_waitrequest, 1);
      bus.slave_write = 1'b0;
      @(negedge slave_clk);
      check_output("full_no_issue", master_issued - base_issued, 0);
      stall_mode = 0;
      for (int i = accepted; i < 20; i++) begin
         apply_stimulus(1'b0, 1'b1, full_addr[i], 4'hF, full_data[i], 400, ok);
         check_output("full_retry_accept", ok, 1);
      end
      wait_drain("full_drain");
      check_output("full_issue_count", master_issued - base_issued, 20);

      $display("[TB] random master stall");
      stall_mode = 2;
      for (int i = 0; i < 30; i++) begin
         rd = 1'($urandom_range(0, 1));
         apply_stimulus(rd, !rd, ADDR_W'($urandom), BE_W'($urandom), $urandom, 400, ok);
         check_output("stall_mix_accept", ok, 1);
      end
      wait_drain("stall_mix_drain");
      check_output("stall_mix_pending", bus.slave_pending_reads, 0);
      stall_mode = 0;

      $display("[TB] simultaneous read/write and credit events");
      base_issued = master_issued;
      apply_stimulus(1'b1, 1'b1, 20'h0ABCD, 4'h5, 32'h12345678, 50, ok);
      check_output("rw_accept", ok, 1);
      repeat (2) @(negedge slave_clk);
      check_output("rw_no_credit", bus.slave_pending_reads, 0);
      wait_drain("rw_drain");
      check_output("rw_one_issue", master_issued - base_issued, 1);
      apply_stimulus(1'b1, 1'b0, 20'h00321, 4'hF, 32'h0, 50, ok);
      for (int n = 0; n < 2000 && !bus.slave_readdatavalid; n++) @(negedge slave_clk);
      check_output("coincide_valid_seen", bus.slave_readdatavalid, 1);
      apply_stimulus(1'b1, 1'b0, 20'h00322, 4'hF, 32'h0, 1, ok);
      check_output("coincide_accept", ok, 1);
      check_output("coincide_pending", bus.slave_pending_reads, 1);
      wait_drain("coincide_drain");
      check_output("coincide_pending_zero", bus.slave_pending_reads, 0);

      $display("[TB] reset mid-operation");
      stall_mode = 1;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(i >= 6, i < 6, ADDR_W'($urandom), 4'hF, $urandom, 50, ok);
         check_output("pre_rst_accept", ok, 1);
      end
      repeat (4) @(negedge slave_clk);
      mon_enable    = 1'b0;
      slave_reset_n = 1'b0;
      #1 check_output("midrst_waitrequest", bus.slave_waitrequest, 1);
      exp_cmd.delete();
      exp_rd.delete();
      rsp_due.delete();
      rsp_data.delete();
      repeat (SYNC) @(posedge master_clk);
      #1 check_output("midrst_master_rw", {bus.master_read, bus.master_write}, 0);
      base_issued = master_issued;
      stall_mode  = 0;
      repeat (4) @(negedge slave_clk);
      slave_reset_n = 1'b1;
      repeat (3) @(negedge slave_clk);
      mon_enable = 1'b1;
      repeat (30) @(negedge slave_clk);
      check_output("post_rst_no_stale", master_issued - base_issued, 0);
      check_output("post_rst_pending", bus.slave_pending_reads, 0);
      apply_stimulus(1'b0, 1'b1, 20'h00777, 4'hC, 32'hCAFEF00D, 50, ok);
      check_output("post_rst_wr_accept", ok, 1);
      apply_stimulus(1'b1, 1'b0, 20'h00778, 4'hF, 32'h0, 50, ok);
      check_output("post_rst_rd_accept", ok, 1);
      wait_drain("post_rst_drain");
      check_output("post_rst_issue_count", master_issued - base_issued, 2);
      check_output("post_rst_pending_zero", bus.slave_pending_reads, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/avalon_mm_clock_crossing_bridge.md
Name: avalon_mm_clock_crossing_bridge

Overview:
Parametrised Avalon-MM clock-crossing bridge that moves read/write commands from a slave port (slave_clk) to a master port (master_clk) and returns read data. It uses two internal gray-pointer asynchronous FIFOs: a command FIFO downstream and a response FIFO upstream. A slave-side read-credit counter guarantees the response FIFO can never overflow, so the master port needs no almost-full threshold. It sits between the CPU-side interconnect and slow peripheral interconnects.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
ADDR_W, 20, slave word-address width.
CMD_DEPTH, 16, command FIFO entries; power of 2, at least 4.
RSP_DEPTH, 32, response FIFO entries; power of 2, at least 4.
MAX_PENDING_READS, 32, maximum outstanding reads; must be at most RSP_DEPTH.
SYNC_STAGES, 2, synchroniser flops for pointers and resets; at least 2.

Ports:
slave_clk  in  1  slave-domain clock
slave_reset_n  in  1  slave-domain reset
master_clk  in  1  master-domain clock
master_reset_n  in  1  master-domain reset, asynchronous, active-low
slave_address  in  ADDR_W  word address
slave_byteenable  in  DATA_W/8  byte enables
slave_read  in  1  read request
slave_write  in  1  write request
slave_writedata  in  DATA_W  write data
slave_waitrequest  out  1  command stall
slave_readdata  out  DATA_W  returned read data
slave_readdatavalid  out  1  read data strobe
slave_pending_reads  out  clog2(MAX_PENDING_READS+1)  outstanding reads
master_address  out  ADDR_W+clog2(DATA_W/8)  byte address (word address with low zero bits appended)
master_byteenable  out  DATA_W/8  byte enables
master_read  out  1  read request
master_write  out  1  write request
master_writedata  out  DATA_W  write data
master_waitrequest  in  1  downstream stall
master_readdata  in  DATA_W  downstream read data
master_readdatavalid  in  1  downstream read data strobe

Behaviour:
- Clock and reset: reset slave_reset_n, asynchronous, active-low; clock slave_clk. master_reset_n and master_clk govern the master domain.
- Reset crossing: each reset is carried into the other domain by an SYNC_STAGES reset synchroniser (asynchronous assert, synchronous deassert). Each domain's effective reset is its own reset OR the synchronised reset of the other domain.
- Values during effective reset: slave_waitrequest=1, slave_readdatavalid=0, slave_readdata=0, slave_pending_reads=0, master_read=0, master_write=0, master_address/byteenable/writedata=0. Both FIFOs' pointers clear.
- Reset mid-operation: all queued commands and responses are discarded. master_readdatavalid is ignored while the master domain is in reset. Responses to reads issued before reset are out of contract; the downstream must be reset with the bridge.
- Slave accept rule: slave_waitrequest = reset | cmd_full | (slave_read & !slave_write & pending==MAX_PENDING_READS). A command is accepted on a slave_clk edge when (read|write) & !waitrequest.
- Read and write both high: treated as a write only; no credit is consumed.
- Command word: {is_read, address, byteenable, writedata}. Exactly CMD_DEPTH entries are usable; full/empty are derived from gray pointers synchronised through SYNC_STAGES flops.
- Credit counter: +1 on an accepted read; -1 on slave_readdatavalid; unchanged when both occur in the same cycle. The counter never exceeds MAX_PENDING_READS and never wraps below 0.
- Master issue: the command FIFO is show-ahead. master_read = !cmd_empty & is_read; master_write = !cmd_empty & !is_read. Address, byteenable and writedata come from the head entry.
- Master hold and pop: outputs hold stable while master_waitrequest=1. The head entry pops on a master_clk edge with a request asserted and master_waitrequest=0; the next entry may issue in the following cycle (back-to-back).
- Command latency: an accepted command reaches the master port no earlier than SYNC_STAGES+1 master_clk edges after acceptance.
- Response path: every master_readdatavalid pushes master_readdata into the response FIFO with no backpressure; credits guarantee free space. A push into a full response FIFO is a design error and fires a simulation assertion.
- Response drain: the slave side pops one entry per slave_clk when the response FIFO is non-empty. slave_readdatavalid and slave_readdata are registered (1 cycle after the pop decision); slave_readdata holds its last value when valid=0.
- Ordering: commands are issued in acceptance order, and read data returns in read order.

Test Plan:
- Single write: write addr 0x00010, be 0xF, data 0xDEADBEEF with slave_clk 50 MHz and master_clk 27 MHz -> one master_write cycle with master_address 0x00040, be 0xF, data 0xDEADBEEF; slave_waitrequest=0 at accept.
- Read burst beyond credit: 40 back-to-back reads, MAX_PENDING_READS=32, downstream returns data equal to the address after 10 cycles -> slave_waitrequest rises once pending reaches 32; 40 readdatavalid pulses in order with correct data; slave_pending_reads returns to 0.
- Command FIFO full: hold master_waitrequest=1 and issue 20 writes -> exactly 16 accepted and waitrequest=1 after that; release waitrequest -> all 20 writes appear in order, none duplicated or lost.
- Master stall: toggle master_waitrequest on a random 50% pattern during mixed reads and writes -> master outputs never change while stalled; response data order and values match a scoreboard.
- Simultaneous read and write, plus simultaneous credit events: assert both strobes -> one write issued and pending unchanged; a read accept coinciding with readdatavalid -> pending unchanged.
- Reset mid-operation: assert slave_reset_n low with 8 commands queued -> slave_waitrequest=1 and master_read/write=0 within SYNC_STAGES master_clk edges; after release, FIFOs are empty, pending=0, and no stale command is issued.
